synaptic_current_accumulator: RTL and testbench

Computes per-neuron synaptic input current for one simulation step of the HOMIN neuron array: for each post-synaptic neuron i, sums W[i][j] over every pre-synaptic neuron j that spiked in the previous step, then adds a common external current. It reads weights from an external synchronous weight RAM and emits one 16-bit Q6.9 current per neuron. It sits directly upstream of the neuron array and replaces the behavioural current computation in the network bench.

---
 rtl/synaptic_current_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_synaptic_current_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_current_accumulator.sv
// Per-neuron synaptic current: sums spiking-neighbour weights from an external sync RAM, adds i_ext (SYN_SATURATE_EN clamps, else wraps).
// One address per cycle; row r emitted N*r+N+2 cycles after start; no backpressure, the weight RAM must answer every cycle.
module synaptic_current_accumulator #(
    parameter int N         = 1000,
    parameter int W_WIDTH   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int ADDR_W    = $clog2(N*N),
    parameter int IDX_W     = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N-1:0]              spike_in,
    input  logic signed [15:0]        i_ext,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic signed [W_WIDTH-1:0] w_data,
    output logic                      cur_valid,
    output logic [IDX_W-1:0]          cur_idx,
    output logic signed [15:0]        cur_data,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [IDX_W-1:0]  LP_LAST_IDX  = IDX_W'(N-1);
    localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(N*N-1);

    logic [1:0]           r_state;
    logic [N-1:0]         r_spike;
    logic [15:0]          r_iext;
    logic [IDX_W-1:0]     r_row;
    logic [IDX_W-1:0]     r_col;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_w_addr;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_busy;
    logic                 r_done;

    // Stage 1 travels with w_addr, stage 2 lines up with the returning w_data.
    logic                 r_p1_vld;
    logic                 r_p1_spk;
    logic                 r_p1_last;
    logic [IDX_W-1:0]     r_p1_row;
    logic                 r_p2_vld;
    logic                 r_p2_spk;
    logic                 r_p2_last;
    logic [IDX_W-1:0]     r_p2_row;

    logic                 r_cur_vld;
    logic [IDX_W-1:0]     r_cur_idx;
    logic [15:0]          r_cur_dat;

    logic [ACC_WIDTH-1:0] w_wext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [15:0]          w_cur;
    logic                 w_final;
`ifdef SYN_SATURATE_EN
    logic [ACC_WIDTH:0]   w_ext_sum;
`endif

    always_comb begin
        w_wext = '0;
        if (r_p2_spk) begin
            w_wext = {{(ACC_WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data};
        end
        w_sum = r_acc + w_wext;
`ifdef SYN_SATURATE_EN
        w_ext_sum = {w_sum[ACC_WIDTH-1], w_sum} + {{(ACC_WIDTH+1-16){r_iext[15]}}, r_iext};
        // In range when every bit above bit 15 matches the sign.
        if ((&w_ext_sum[ACC_WIDTH:15]) || ~(|w_ext_sum[ACC_WIDTH:15])) begin
            w_cur = w_ext_sum[15:0];
        end else if (w_ext_sum[ACC_WIDTH]) begin
            w_cur = 16'h8000;
        end else begin
            w_cur = 16'h7FFF;
        end
`else
        w_cur = w_sum[15:0] + r_iext;
`endif
    end

    assign w_final = r_p2_vld && r_p2_last && (r_p2_row == LP_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_spike   <= '0;
            r_iext    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_addr    <= '0;
            r_w_addr  <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p1_vld  <= 1'b0;
            r_p1_spk  <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_row  <= '0;
            r_p2_vld  <= 1'b0;
            r_p2_spk  <= 1'b0;
            r_p2_last <= 1'b0;
            r_p2_row  <= '0;
            r_cur_vld <= 1'b0;
            r_cur_idx <= '0;
            r_cur_dat <= '0;
        end else begin
            r_p1_vld  <= 1'b0;
            r_cur_vld <= 1'b0;
            r_done    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_spike <= spike_in;
                        r_iext  <= i_ext;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_addr  <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_w_addr  <= r_addr;
                    r_p1_vld  <= 1'b1;
                    r_p1_spk  <= r_spike[r_col];
                    r_p1_last <= (r_col == LP_LAST_IDX);
                    r_p1_row  <= r_row;
                    if (r_col == LP_LAST_IDX) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == LP_LAST_ADDR) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_final) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            r_p2_vld  <= r_p1_vld;
            r_p2_spk  <= r_p1_spk;
            r_p2_last <= r_p1_last;
            r_p2_row  <= r_p1_row;

            if (r_p2_vld) begin
                if (r_p2_last) begin
                    r_cur_vld <= 1'b1;
                    r_cur_idx <= r_p2_row;
                    r_cur_dat <= w_cur;
                    r_acc     <= '0;
                end else begin
                    r_acc     <= w_sum;
                end
            end
        end
    end

    assign w_addr    = r_w_addr;
    assign cur_valid = r_cur_vld;
    assign cur_idx   = r_cur_idx;
    assign cur_data  = r_cur_dat;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Bench for synaptic_current_accumulator at N=4 with a synchronous weight RAM model.
module tb_synaptic_current_accumulator;

    localparam int N  = 4;
    localparam int NN = N * N;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [N-1:0]       spike_in;
    logic signed [15:0] i_ext;
    logic [3:0]         w_addr;
    logic signed [15:0] w_data;
    logic               cur_valid;
    logic [1:0]         cur_idx;
    logic signed [15:0] cur_data;
    logic               busy;
    logic               done;

    logic signed [15:0] mem [NN];

    int n_cmp  = 0;
    int n_fail = 0;

    synaptic_current_accumulator #(
        .N(N), .W_WIDTH(16), .ACC_WIDTH(32), .ADDR_W(4), .IDX_W(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .i_ext(i_ext),
        .w_addr(w_addr), .w_data(w_data), .cur_valid(cur_valid), .cur_idx(cur_idx),
        .cur_data(cur_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) w_data <= mem[w_addr];

    typedef struct {
        logic [N-1:0]       spk;
        logic [15:0]        iext;
        int                 wmode;
        logic [N-1:0][15:0] exp_wrap;
        logic [N-1:0][15:0] exp_sat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic load_w(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0:       mem[i*N+j] = 16'(10*i + j);
                    1:       mem[i*N+j] = 16'sd16000;
                    2:       mem[i*N+j] = -16'sd20000;
                    default: mem[i*N+j] = 16'($urandom);
                endcase
            end
        end
    endtask

    // Reference: plain integer sum of spiking weights plus external current.
    function automatic logic [15:0] model_cur(input int i, input logic [N-1:0] spk,
                                              input logic signed [15:0] e);
        int s;
        s = int'(e);
        for (int j = 0; j < N; j++) begin
            if (spk[j]) s += int'(mem[i*N+j]);
        end
`ifdef SYN_SATURATE_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic model_all(input logic [N-1:0] spk, input logic signed [15:0] e,
                             output logic [N-1:0][15:0] expv);
        for (int i = 0; i < N; i++) expv[i] = model_cur(i, spk, e);
    endtask

    // Cycle k is the negedge following edge E(k) of the step.
    task automatic run_step(input logic [N-1:0] spk, input logic signed [15:0] e,
                            input logic [N-1:0][15:0] expv, input bit mutate, input bit hold);
        int  guard;
        bit  exp_v;
        int  r;
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_start", {31'd0, busy}, 32'd0);
        start    = 1'b1;
        spike_in = spk;
        i_ext    = e;
        @(posedge clk);
        for (int k = 0; k <= NN + 3; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            if (mutate) begin
                start    = (k >= NN + 2) ? 1'b0 : 1'($urandom_range(0, 1));
                spike_in = N'($urandom);
                i_ext    = 16'($urandom);
            end else if (!hold) begin
                start = 1'b0;
            end
            @(negedge clk);
            exp_v = (k >= N + 2) && (k <= NN + 2) && (((k - 2) % N) == 0);
            chk("cur_valid", {31'd0, cur_valid}, {31'd0, exp_v});
            chk("done", {31'd0, done}, {31'd0, (k == NN + 2)});
            chk("busy", {31'd0, busy}, {31'd0, (k <= NN + 2)});
            if (exp_v) begin
                r = (k - 2) / N - 1;
                chk("cur_idx", {30'd0, cur_idx}, 32'(r));
                chk("cur_data", {16'd0, cur_data}, {16'd0, expv[r]});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0][15:0] expv;
        logic [N-1:0]       spk;
        logic signed [15:0] e;
        bit                 seen;

        tbl[0] = '{spk: 4'b0000, iext: 16'h1E00, wmode: 0,
                   exp_wrap: {16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00},
                   exp_sat:  {16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00}};
        tbl[1] = '{spk: 4'b0101, iext: 16'h0000, wmode: 0,
                   exp_wrap: {16'd62, 16'd42, 16'd22, 16'd2},
                   exp_sat:  {16'd62, 16'd42, 16'd22, 16'd2}};
        tbl[2] = '{spk: 4'b1111, iext: 16'h0000, wmode: 1,
                   exp_wrap: {16'hFA00, 16'hFA00, 16'hFA00, 16'hFA00},
                   exp_sat:  {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};
        tbl[3] = '{spk: 4'b1111, iext: 16'hE200, wmode: 2,
                   exp_wrap: {16'hA980, 16'hA980, 16'hA980, 16'hA980},
                   exp_sat:  {16'h8000, 16'h8000, 16'h8000, 16'h8000}};

        rst      = 1'b1;
        start    = 1'b0;
        spike_in = '0;
        i_ext    = '0;
        load_w(0);
        repeat (2) @(negedge clk);
        chk("rst_w_addr", {28'd0, w_addr}, 32'd0);
        chk("rst_cur_valid", {31'd0, cur_valid}, 32'd0);
        chk("rst_cur_idx", {30'd0, cur_idx}, 32'd0);
        chk("rst_cur_data", {16'd0, cur_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_w(tbl[v].wmode);
`ifdef SYN_SATURATE_EN
            expv = tbl[v].exp_sat;
`else
            expv = tbl[v].exp_wrap;
`endif
            run_step(tbl[v].spk, 16'(tbl[v].iext), expv, 1'b0, 1'b0);
        end

        for (int t = 0; t < 6; t++) begin
            load_w(3);
            spk = N'($urandom);
            e   = (t == 2) ? 16'sh7FFF : (t == 3) ? 16'sh8000 : 16'($urandom);
            model_all(spk, e, expv);
            run_step(spk, e, expv, (t % 2) == 1, 1'b0);
        end

        // Abort mid-run while row 0's strobe is up.
        load_w(0);
        start    = 1'b1;
        spike_in = 4'hF;
        i_ext    = 16'sd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_cur_valid", {31'd0, cur_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cur_valid", {31'd0, cur_valid}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_w_addr", {28'd0, w_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cur_valid || done || busy) seen = 1'b1;
        end
        chk("no_activity_after_rst", {31'd0, seen}, 32'd0);
        model_all(4'hF, 16'sd0, expv);
        run_step(4'hF, 16'sd0, expv, 1'b0, 1'b0);

        // start held high: steps chain back-to-back.
        load_w(3);
        spk = N'($urandom);
        e   = 16'($urandom);
        model_all(spk, e, expv);
        for (int s = 0; s < 3; s++) run_step(spk, e, expv, 1'b0, 1'b1);
        start = 1'b0;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (cur_valid || done || busy) seen = 1'b1;
        end
        chk("idle_after_hold", {31'd0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
